// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared constants, output-mode encoding and helper functions
//                for the PWM peripheral and its timebase.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    // Last value of the step counter; it wraps to zero after this
    localparam logic [7:0] PWM_STEP_MAX        = 8'd254;
    // Number of steps in one PWM period (0..PWM_STEP_MAX)
    localparam int         PWM_PERIOD_STEPS    = 255;
    // Default number of clk cycles per PWM step
    localparam int         PWM_CLK_DIV_DEFAULT = 13;
    // Number of user outputs
    localparam int         OUT_WIDTH           = 16;

    // How a single output bit is driven
    typedef enum logic [1:0] {
        OUT_MODE_OFF  = 2'd0,
        OUT_MODE_HIGH = 2'd1,
        OUT_MODE_PWM  = 2'd2
    } out_mode_t;

    // Prescaler width: enough bits to hold CLK_DIV-1, never less than one bit
    function automatic int prescale_width(input int div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

    // Output-enable has priority: a disabled bit is off whatever the PWM select says
    function automatic out_mode_t decode_mode(input logic en_out, input logic en_pwm);
        if (!en_out) begin
            return OUT_MODE_OFF;
        end else if (!en_pwm) begin
            return OUT_MODE_HIGH;
        end else begin
            return OUT_MODE_PWM;
        end
    endfunction

    // Next value of one output bit given its enables and the shared waveform
    function automatic logic out_select(input logic en_out, input logic en_pwm,
                                        input logic pwm_sig);
        logic v;
        v = 1'b0;
        case (decode_mode(en_out, en_pwm))
            OUT_MODE_HIGH: v = 1'b1;
            OUT_MODE_PWM:  v = pwm_sig;
            default:       v = 1'b0;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_timebase.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_timebase
//  Description : Clock prescaler plus 8-bit step counter (0..254). Exports the
//                current step and a combinational flag marking the first clk
//                of every PWM period.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = PWM_CLK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] step_count,
    output logic       period_start_comb
);

    localparam int                c_ps_w    = prescale_width(CLK_DIV);
    localparam logic [c_ps_w-1:0] c_ps_last = c_ps_w'(CLK_DIV - 1);

    logic [c_ps_w-1:0] r_prescaler;
    logic [7:0]        r_step_count;
    logic              w_step_tick;

    assign w_step_tick       = (r_prescaler == c_ps_last);
    assign period_start_comb = (r_prescaler == '0) && (r_step_count == 8'd0);
    assign step_count        = r_step_count;

    // Prescaler counts 0..CLK_DIV-1; step counter advances on each wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescaler  <= '0;
            r_step_count <= 8'd0;
        end else begin
            if (w_step_tick) begin
                r_prescaler <= '0;
                if (r_step_count == PWM_STEP_MAX) begin
                    r_step_count <= 8'd0;
                end else begin
                    r_step_count <= r_step_count + 8'd1;
                end
            end else begin
                r_prescaler <= r_prescaler + c_ps_w'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_peripheral.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_peripheral
//  Description : Drives 16 user outputs as off, static high or a shared PWM
//                waveform. The duty value is double-buffered and only taken
//                at a period boundary so every period is glitch-free.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = PWM_CLK_DIV_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           en_reg_out_7_0,
    input  logic [7:0]           en_reg_out_15_8,
    input  logic [7:0]           en_reg_pwm_7_0,
    input  logic [7:0]           en_reg_pwm_15_8,
    input  logic [7:0]           pwm_duty_cycle,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 period_start
);

    logic [7:0]           w_step_count;
    logic                 w_period_start_comb;
    logic [7:0]           r_duty_shadow;
    logic [7:0]           w_duty_eff;
    logic                 w_pwm_sig;
    logic [OUT_WIDTH-1:0] w_en_out;
    logic [OUT_WIDTH-1:0] w_en_pwm;
    logic [OUT_WIDTH-1:0] w_out_next;
    logic [OUT_WIDTH-1:0] r_out;
    logic                 r_period_start;

    pwm_timebase #(
        .CLK_DIV (CLK_DIV)
    ) u_timebase (
        .clk               (clk),
        .rst_n             (rst_n),
        .step_count        (w_step_count),
        .period_start_comb (w_period_start_comb)
    );

    assign w_en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign w_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // The value written on the boundary clk is used for that very period
    assign w_duty_eff = w_period_start_comb ? pwm_duty_cycle : r_duty_shadow;
    // Step never exceeds 254, so a duty of 0xFF keeps the waveform high
    assign w_pwm_sig  = (w_step_count < w_duty_eff);

    for (genvar gi = 0; gi < OUT_WIDTH; gi++) begin : g_out_bit
        assign w_out_next[gi] = out_select(w_en_out[gi], w_en_pwm[gi], w_pwm_sig);
    end

    // Duty shadow captures the requested duty only at a period boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_shadow <= 8'h00;
        end else if (w_period_start_comb) begin
            r_duty_shadow <= pwm_duty_cycle;
        end
    end

    // Register outputs and the period marker together so they stay aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_out          <= w_out_next;
            r_period_start <= w_period_start_comb;
        end
    end

    assign out          = r_out;
    assign period_start = r_period_start;

endmodule
`default_nettype wire

// File: tb/tb_pwm_peripheral.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_peripheral
//  Description : Self-checking bench for pwm_peripheral. Two instances (default
//                divider and divider 1) share the same stimulus and are
//                compared every cycle against a period/phase arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_peripheral;
    import pwm_pkg::*;

    localparam int D0 = PWM_CLK_DIV_DEFAULT;
    localparam int D1 = 1;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  eo_lo = 8'hFF;
    logic [7:0]  eo_hi = 8'hFF;
    logic [7:0]  ep_lo = 8'hFF;
    logic [7:0]  ep_hi = 8'hFF;
    logic [7:0]  duty  = 8'hFF;
    logic [15:0] out0;
    logic [15:0] out1;
    logic        ps0;
    logic        ps1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pwm_peripheral #(.CLK_DIV(D0)) u_dut0 (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (eo_lo),
        .en_reg_out_15_8 (eo_hi),
        .en_reg_pwm_7_0  (ep_lo),
        .en_reg_pwm_15_8 (ep_hi),
        .pwm_duty_cycle  (duty),
        .out             (out0),
        .period_start    (ps0)
    );

    pwm_peripheral #(.CLK_DIV(D1)) u_dut1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (eo_lo),
        .en_reg_out_15_8 (eo_hi),
        .en_reg_pwm_7_0  (ep_lo),
        .en_reg_pwm_15_8 (ep_hi),
        .pwm_duty_cycle  (duty),
        .out             (out1),
        .period_start    (ps1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: k counts clk edges since reset release; period phase,
    // step and boundary all follow from k by plain division.
    int          k_m      [2];
    logic [7:0]  shadow_m [2];
    logic [15:0] exp_out  [2];
    logic        exp_ps   [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                k_m[d]      = 0;
                shadow_m[d] = 8'h00;
                exp_out[d]  = 16'h0000;
                exp_ps[d]   = 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                int          div;
                int          pos;
                int          step;
                logic        pwm;
                logic [15:0] eo;
                logic [15:0] ep;
                div  = (d == 0) ? D0 : D1;
                pos  = k_m[d] % (PWM_PERIOD_STEPS * div);
                step = pos / div;
                if (pos == 0) shadow_m[d] = duty;
                pwm  = (step < int'(shadow_m[d]));
                eo   = {eo_hi, eo_lo};
                ep   = {ep_hi, ep_lo};
                for (int i = 0; i < 16; i++) begin
                    exp_out[d][i] = !eo[i] ? 1'b0 : (!ep[i] ? 1'b1 : pwm);
                end
                exp_ps[d] = (pos == 0);
                k_m[d]++;
            end
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        check("out_div13", out0, exp_out[0]);
        check("ps_div13",  ps0,  exp_ps[0]);
        check("out_div1",  out1, exp_out[1]);
        check("ps_div1",   ps1,  exp_ps[1]);
    end

    // Advance to a negedge where the divider-1 instance shows a period start
    task automatic wait_ps1(input int budget);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            seen = ps1;
        end
        check("ps1_seen_within_budget", seen, 1);
    endtask

    // Count high samples of out1[0] across one 255-clk period, starting at the
    // current (period-start) negedge; optionally write a new duty after sample
    // at_idx. Ends on the first sample of the following period.
    task automatic count_highs(output int highs, input int at_idx, input logic [7:0] new_duty);
        highs = 0;
        for (int i = 0; i < PWM_PERIOD_STEPS; i++) begin
            if (i > 0) @(negedge clk);
            highs += int'(out1[0]);
            if (i == at_idx) begin
                #1 duty = new_duty;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        bit found;
        int h;

        // Reset held with every input at all-ones
        repeat (5) @(negedge clk);
        check("reset_out_div13", out0, 16'h0000);
        check("reset_ps_div13",  ps0,  0);
        check("reset_out_div1",  out1, 16'h0000);
        check("reset_ps_div1",   ps1,  0);

        #1 rst_n = 1'b1;
        @(negedge clk);
        check("first_ps_div13", ps0, 1);
        check("first_ps_div1",  ps1, 1);

        // Period length of the default divider: 255*13 clks
        cnt   = 0;
        found = 1'b0;
        while (!found && cnt < 4000) begin
            @(negedge clk);
            cnt++;
            if (ps0) found = 1'b1;
        end
        check("period_len_div13", cnt, 3315);

        // Static drive, then disabled output overriding PWM select
        #1;
        eo_lo = 8'h01; eo_hi = 8'h00; ep_lo = 8'h00; ep_hi = 8'h00; duty = 8'h80;
        @(negedge clk);
        check("static_high_div13", out0, 16'h0001);
        check("static_high_div1",  out1, 16'h0001);
        #1;
        eo_lo = 8'h00; ep_lo = 8'h01;
        @(negedge clk);
        check("disabled_div13", out0, 16'h0000);
        check("disabled_div1",  out1, 16'h0000);

        // Duty accuracy: 0x80 gives 128 high clks per 255-clk period
        #1;
        eo_lo = 8'hFF; eo_hi = 8'hFF; ep_lo = 8'hFF; ep_hi = 8'hFF; duty = 8'h80;
        wait_ps1(600);
        for (int p = 0; p < 3; p++) begin
            count_highs(h, -1, 8'h00);
            check("duty80_highs", h, 128);
            check("duty80_next_ps", ps1, 1);
        end

        // Extremes
        #1 duty = 8'h00;
        wait_ps1(600);
        count_highs(h, -1, 8'h00);
        check("duty00_highs_p0", h, 0);
        count_highs(h, -1, 8'h00);
        check("duty00_highs_p1", h, 0);
        #1 duty = 8'hFF;
        wait_ps1(600);
        count_highs(h, -1, 8'hFF);
        check("dutyFF_highs_p0", h, 255);
        count_highs(h, -1, 8'hFF);
        check("dutyFF_highs_p1", h, 255);

        // Double buffering: mid-period write waits; boundary write applies now
        #1 duty = 8'h40;
        wait_ps1(600);
        count_highs(h, 100, 8'hC0);
        check("buffered_old_duty", h, 64);
        count_highs(h, 254, 8'h20);
        check("buffered_new_duty", h, 192);
        count_highs(h, -1, 8'h20);
        check("boundary_write_duty", h, 32);

        // Randomised enables, duty and occasional reset pulses
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 7) == 0) eo_lo = 8'($urandom);
            if ($urandom_range(0, 7) == 0) eo_hi = 8'($urandom);
            if ($urandom_range(0, 7) == 0) ep_lo = 8'($urandom);
            if ($urandom_range(0, 7) == 0) ep_hi = 8'($urandom);
            if ($urandom_range(0, 49) == 0) duty = 8'($urandom);
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                #1 rst_n = 1'b1;
            end
        end

        // Mixed static/PWM bits, then asynchronous reset mid-period
        @(negedge clk);
        #1;
        eo_lo = 8'hA5; eo_hi = 8'hA5; ep_lo = 8'hFF; ep_hi = 8'h00; duty = 8'h40;
        wait_ps1(600);
        repeat (50) @(negedge clk);
        check("mixed_step50_div1", out1, 16'hA5A5);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_out_div13", out0, 16'h0000);
        check("async_rst_out_div1",  out1, 16'h0000);
        check("async_rst_ps_div13",  ps0,  0);
        check("async_rst_ps_div1",   ps1,  0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("release_ps_div13",  ps0,  1);
        check("release_ps_div1",   ps1,  1);
        check("release_out_div13", out0, 16'hA5A5);
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
Downstream consumer of the SPI register file. It takes the output-enable, PWM-enable and duty-cycle registers and drives 16 user outputs. Each output is forced low, held high, or driven by one shared PWM waveform. Duty updates are double-buffered so that a new value only takes effect at a period boundary, which keeps every period glitch-free.

Parameters:
CLK_DIV, 13, clk cycles per PWM step; legal range 1..65535. At 10 MHz the PWM frequency is 10e6/(13*255), about 3.02 kHz.

Ports:
clk  in  1  system clock; single clock domain
rst_n  in  1  reset, asynchronous assert, active-low
en_reg_out_7_0  in  8  output enable for bits 7:0
en_reg_out_15_8  in  8  output enable for bits 15:8
en_reg_pwm_7_0  in  8  PWM-mode select for bits 7:0
en_reg_pwm_15_8  in  8  PWM-mode select for bits 15:8
pwm_duty_cycle  in  8  requested duty, 0x00..0xFF
out  out  16  user outputs; bit i maps to enable bit i
period_start  out  1  one-clk pulse at the first clk of each PWM period

Behaviour:
- Reset (rst_n low, async): prescaler=0, step counter=0, duty shadow=0x00, out=16'h0000, period_start=0.
- Prescaler:
  - Counts 0..CLK_DIV-1 every clk and wraps to 0.
  - step_tick is asserted when prescaler==CLK_DIV-1.
  - CLK_DIV=1 gives step_tick on every clk.
- Step counter:
  - 8 bits, advances on step_tick, counts 0..254 then wraps to 0.
  - Period = 255 steps = 255*CLK_DIV clks.
- Period start:
  - Defined as prescaler==0 && step counter==0, including the first clk after reset release.
  - On that clk the duty shadow loads pwm_duty_cycle.
  - duty_eff = pwm_duty_cycle on that clk, otherwise the shadow value.
- PWM signal (combinational): pwm_sig = (step counter < duty_eff).
  - 0x00: permanently low.
  - 0xFF: permanently high, since the counter max is 254.
  - N: high for exactly N*CLK_DIV clks per period, starting at period start.
- Output select, per bit i, evaluated combinationally and registered on the next clk edge:
  - en_out[i]=0: out[i]=0, regardless of en_pwm[i].
  - en_out[i]=1, en_pwm[i]=0: out[i]=1.
  - en_out[i]=1, en_pwm[i]=1: out[i]=pwm_sig.
- Latency:
  - Enable-register change to out: 1 clk.
  - out tracks pwm_sig with 1 clk delay.
  - period_start is registered with the same 1 clk delay, so it aligns with the first out sample of the period.
- Mid-period duty change: ignored until the next period start. The current period completes with the old duty.
- Simultaneous duty write and period start: the new value applies to the period that is starting.
- Enable changes: take effect immediately (1 clk). Counters are never reset by them.
- Reset mid-period: everything returns to reset values. The first period after release starts on the first clk and uses the duty present then.
- No arithmetic overflow:
  - Prescaler width is $clog2(CLK_DIV), minimum 1.
  - The step-counter compare is an unsigned 8-bit compare.

Decomposition:
- Shared package pwm_pkg holds:
  - PWM_STEP_MAX = 8'd254
  - PWM_PERIOD_STEPS = 255
  - PWM_CLK_DIV_DEFAULT = 13
  - OUT_WIDTH = 16
- One sub-module, pwm_timebase: prescaler plus step counter. It exports step_count[7:0] and period_start_comb.
- The top level holds the duty shadow, the compare and the registered output mux.

Test Plan:
1. Reset: hold rst_n=0 with all inputs 0xFF -> out=0x0000 and period_start=0. Release -> period_start pulses 1 clk after release, then every 255*CLK_DIV clks (3315 with the default).
2. Static drive: en_out_7_0=0x01, en_pwm=0, duty=0x80 -> out=0x0001 one clk after the write. Then set en_out_7_0=0x00 with en_pwm_7_0=0x01 -> out=0x0000.
3. Duty accuracy (CLK_DIV=1): en_out=en_pwm=0xFFFF, duty=0x80 -> all outputs high 128 clks, low 127 clks, per 255-clk period, repeated over 3 periods.
4. Extremes: duty=0x00 -> out stays 0x0000 for 2 full periods. duty=0xFF -> out stays 0xFFFF with no low clk.
5. Double buffering: duty=0x40, then write 0xC0 at step 100 -> current period has 64 high steps, next period has 192. A write landing exactly on period start applies immediately.
6. Mixed bits with async reset mid-period: en_out=0xA5A5, en_pwm=0x00FF, duty=0x40 -> bits 15:8 static per en_out (pattern 0xA5), bits 7:0 PWM-gated by 0xA5. Pulse rst_n low at step 50 -> out=0 immediately, and a fresh period_start follows release.
